avalon_pio_multi: RTL and testbench
===================================

Name: avalon_pio_multi

Overview:
- Parametrised Avalon-MM slave parallel I/O block; successor to the fixed 8-bit LED export PIO in the lab SoC.
- Provides NUM_CH independent channels, each DATA_W bits wide, with:
  - output register plus atomic set and clear registers;
  - synchronised inputs with edge capture;
  - a masked interrupt.
- Sits on the Nios II data bus alongside the SDRAM controller; drives LEDs and reads switches and keys.

Parameters:
- NUM_CH, 2, number of channels (1..8).
- DATA_W, 8, bits per channel (1..32).
- OUT_RESET, 0, reset value loaded into every channel's output register (DATA_W bits).
- EDGE_TYPE, 0, edge to capture: 0 rising, 1 falling, 2 any.
- ADDR_W, $clog2(NUM_CH)+3, derived word-address width; must not be overridden.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- avs_address  in  ADDR_W  word address: {channel, reg[2:0]}.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_byteenable  in  4  byte lanes.
- avs_readdata  out  32  read data, fixed latency 1.
- pio_in  in  NUM_CH*DATA_W  asynchronous inputs; channel c occupies [c*DATA_W +: DATA_W].
- pio_out  out  NUM_CH*DATA_W  registered outputs.
- irq  out  1  level interrupt, active high.

Behaviour:
- Interface rules:
  - No waitrequest.
  - Reads have fixed latency 1: avs_readdata is registered on the cycle after avs_read.
  - Unused upper bits of avs_readdata read 0.
  - Channel index >= NUM_CH: reads return 0, writes are ignored.
- Register map, per channel (reg field):
  - 0 DATA: R/W. Write honours byteenable. Read returns the output register.
  - 1 IN: RO. Returns the synchronised input.
  - 2 MASK: R/W. IRQ mask, honours byteenable.
  - 3 EDGE: R/W1C. Edge capture bits.
  - 4 SET: WO. out |= wdata. Reads 0.
  - 5 CLR: WO. out &= ~wdata. Reads 0.
  - 6 and 7: reserved, read 0.
- Input path:
  - Each pio_in bit passes through a 2-flop synchroniser, then a 1-flop history register.
  - An edge is detected on the synchronised value per EDGE_TYPE.
  - Pin-to-EDGE-bit latency is 3 cycles.
- Edge capture:
  - A detected edge sets its EDGE bit; the bit is sticky until software writes 1 to it.
  - If an edge is detected in the same cycle as a W1C to that bit, the edge wins and the bit stays 1.
- Interrupt:
  - irq is registered: OR over all channels of (EDGE & MASK).
  - irq asserts 1 cycle after the EDGE bit sets and deasserts 1 cycle after the last masked bit clears.
- Output path: pio_out is driven directly from the output registers; it updates 1 cycle after the write.
- Reset values:
  - Output registers = OUT_RESET.
  - MASK, EDGE, synchronisers, history, avs_readdata and irq = 0.
- Reset mid-operation: asserting reset_n clears everything immediately, including any pending read data. After reset release, no spurious edge may be captured from the synchroniser fill, because the history register resets to 0 and synchronised 0 inputs do not edge.

Optional Feature:
- Macro: PIO_PWM_EN.
- Defined:
  - reg 6 becomes DUTY, an 8-bit R/W register per channel, reset value 255.
  - A free-running 8-bit counter is shared by all channels.
  - pio_out bit = out_reg bit AND (counter < DUTY); DUTY 255 means on for 255/256 of cycles, DUTY 0 means always off.
  - A DUTY write takes effect at the next counter wrap (255 -> 0).
- Not defined: reg 6 reads 0; pio_out equals the output register; no counter is synthesised.

Decomposition:
- Package pio_pkg holds:
  - register index localparams REG_DATA .. REG_DUTY;
  - EDGE_RISE, EDGE_FALL and EDGE_ANY constants;
  - the typedef for the 3-bit reg field.
- Sub-module pio_channel is one channel: output register, SET/CLR logic, synchroniser, edge detect, MASK, EDGE and optional DUTY. The top level instantiates NUM_CH of them, then muxes readdata and ORs irq.

Test Plan:
- Reset with OUT_RESET=8'hA5, NUM_CH=2 -> pio_out=16'hA5A5, irq=0 and reads of IN, MASK and EDGE return 0.
- Write ch0 DATA=32'h0000_00FF with byteenable=4'b0000 -> no change. Then SET ch1 0x0F followed by CLR ch1 0x03 -> ch1 out=0xAC (from 0xA5), ch0 out unchanged; readdata appears exactly 1 cycle after read.
- Raise pio_in[3] with EDGE_TYPE=0 and ch0 MASK=0x08 -> EDGE bit 3 set at cycle 3 and irq=1 at cycle 4. W1C 0x08 -> irq=0 one cycle later. Falling edge on the same pin -> no capture.
- W1C to EDGE bit 3 in the same cycle a new edge is detected -> bit remains 1 and irq stays high.
- Access channel index 3 with NUM_CH=2 -> read returns 0 and the write has no effect.
- With PIO_PWM_EN defined: DUTY=64 and out bit=1 -> pio_out high 64 of every 256 cycles. A DUTY write mid-period takes effect only after counter wrap. Reg 6 reads 0 when the macro is not defined.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the multi-channel Avalon PIO: register indices,
// edge-type encodings and the per-channel register select type.
package pio_pkg;

  typedef logic [2:0] reg_sel_t;

  localparam reg_sel_t REG_DATA = 3'd0;
  localparam reg_sel_t REG_IN   = 3'd1;
  localparam reg_sel_t REG_MASK = 3'd2;
  localparam reg_sel_t REG_EDGE = 3'd3;
  localparam reg_sel_t REG_SET  = 3'd4;
  localparam reg_sel_t REG_CLR  = 3'd5;
  localparam reg_sel_t REG_DUTY = 3'd6;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_channel.sv
// One PIO channel: output register with set/clear, input synchroniser, edge capture,
// IRQ mask and, when PIO_PWM_EN is defined, a per-channel PWM duty register.
module pio_channel
  import pio_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] OUT_RESET = '0,
  parameter int                EDGE_TYPE = EDGE_RISE
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef PIO_PWM_EN
  input  logic [7:0]        pwm_cnt,
`endif
  input  logic              wr_en,
  input  reg_sel_t          reg_sel,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  input  logic [DATA_W-1:0] pin,
  output logic [DATA_W-1:0] pout,
  output logic [31:0]       rd_data,
  output logic              irq_req
);

  logic [DATA_W-1:0] out_reg, mask_reg, edge_reg;
  logic [DATA_W-1:0] sync_meta, sync_q, hist_q;
  logic [DATA_W-1:0] be_mask, wd, det;

  assign wd = wdata[DATA_W-1:0];

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < DATA_W; i++) be_mask[i] = be[i/8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= OUT_RESET;
      mask_reg <= '0;
    end else if (wr_en) begin
      case (reg_sel)
        REG_DATA: out_reg  <= (out_reg & ~be_mask) | (wd & be_mask);
        REG_SET:  out_reg  <= out_reg | wd;
        REG_CLR:  out_reg  <= out_reg & ~wd;
        REG_MASK: mask_reg <= (mask_reg & ~be_mask) | (wd & be_mask);
        default: ;
      endcase
    end
  end

  // History resets to 0 so the synchroniser filling with 0 never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
      hist_q    <= '0;
    end else begin
      sync_meta <= pin;
      sync_q    <= sync_meta;
      hist_q    <= sync_q;
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: det = ~sync_q & hist_q;
      EDGE_ANY:  det = sync_q ^ hist_q;
      default:   det = sync_q & ~hist_q;
    endcase
  end

  // A fresh edge overrides a simultaneous write-one-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_reg <= '0;
    else if (wr_en && reg_sel == REG_EDGE) edge_reg <= (edge_reg & ~wd) | det;
    else edge_reg <= edge_reg | det;
  end

  assign irq_req = |(edge_reg & mask_reg);

`ifdef PIO_PWM_EN
  logic [7:0] duty_reg, duty_act;

  // The active duty only reloads on the 255 -> 0 wrap so periods are never torn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_reg <= 8'hFF;
      duty_act <= 8'hFF;
    end else begin
      if (wr_en && reg_sel == REG_DUTY && be[0]) duty_reg <= wdata[7:0];
      if (pwm_cnt == 8'hFF) duty_act <= duty_reg;
    end
  end

  assign pout = out_reg & {DATA_W{pwm_cnt < duty_act}};
`else
  assign pout = out_reg;
`endif

  always_comb begin
    case (reg_sel)
      REG_DATA: rd_data = 32'(out_reg);
      REG_IN:   rd_data = 32'(sync_q);
      REG_MASK: rd_data = 32'(mask_reg);
      REG_EDGE: rd_data = 32'(edge_reg);
`ifdef PIO_PWM_EN
      REG_DUTY: rd_data = 32'(duty_reg);
`endif
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: rtl/avalon_pio_multi.sv
// Avalon-MM slave parallel I/O with NUM_CH channels of DATA_W bits each.
// Optional PWM output gating is enabled by defining PIO_PWM_EN.
module avalon_pio_multi
  import pio_pkg::*;
#(
  parameter int                NUM_CH    = 2,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] OUT_RESET = '0,
  parameter int                EDGE_TYPE = EDGE_RISE,
  localparam int               ADDR_W    = $clog2(NUM_CH) + 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  input  logic [3:0]               avs_byteenable,
  output logic [31:0]              avs_readdata,
  input  logic [NUM_CH*DATA_W-1:0] pio_in,
  output logic [NUM_CH*DATA_W-1:0] pio_out,
  output logic                     irq
);

  logic [ADDR_W-1:0] ch_field;
  reg_sel_t          reg_sel;
  logic [31:0]       ch_rd [NUM_CH];
  logic [NUM_CH-1:0] ch_irq;
  logic [31:0]       rd_mux;

  // Shifting rather than slicing keeps the NUM_CH == 1 case legal.
  assign ch_field = avs_address >> 3;
  assign reg_sel  = avs_address[2:0];

`ifdef PIO_PWM_EN
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt + 8'd1;
  end
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pio_channel #(
      .DATA_W   (DATA_W),
      .OUT_RESET(OUT_RESET),
      .EDGE_TYPE(EDGE_TYPE)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
`ifdef PIO_PWM_EN
      .pwm_cnt(pwm_cnt),
`endif
      .wr_en  (avs_write && ch_field == ADDR_W'(c)),
      .reg_sel(reg_sel),
      .wdata  (avs_writedata),
      .be     (avs_byteenable),
      .pin    (pio_in[c*DATA_W +: DATA_W]),
      .pout   (pio_out[c*DATA_W +: DATA_W]),
      .rd_data(ch_rd[c]),
      .irq_req(ch_irq[c])
    );
  end

  // Channel indices beyond NUM_CH match nothing and read as 0.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (ch_field == ADDR_W'(c)) rd_mux = ch_rd[c];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      avs_readdata <= avs_read ? rd_mux : '0;
      irq          <= |ch_irq;
    end
  end

endmodule

// File: tb/tb_avalon_pio_multi.sv
// Directed self-checking bench for avalon_pio_multi (3 channels so that an
// unmapped channel index is addressable).
module tb_avalon_pio_multi;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [ADDR_W-1:0]        avs_address;
  logic                     avs_read;
  logic                     avs_write;
  logic [31:0]              avs_writedata;
  logic [3:0]               avs_byteenable;
  logic [31:0]              avs_readdata;
  logic [NUM_CH*DATA_W-1:0] pio_in;
  logic [NUM_CH*DATA_W-1:0] pio_out;
  logic                     irq;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  avalon_pio_multi #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .OUT_RESET(8'hA5),
    .EDGE_TYPE(0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_byteenable(avs_byteenable),
    .avs_readdata  (avs_readdata),
    .pio_in        (pio_in),
    .pio_out       (pio_out),
    .irq           (irq)
  );

  // Bus tasks start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic [1:0] ch, input logic [2:0] rg,
                           input logic [31:0] data, input logic [3:0] be);
    avs_address    = {ch, rg};
    avs_writedata  = data;
    avs_byteenable = be;
    avs_write      = 1'b1;
    @(posedge clk); #1;
    avs_write      = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] ch, input logic [2:0] rg, output logic [31:0] data);
    avs_address = {ch, rg};
    avs_read    = 1'b1;
    @(posedge clk); #1;
    avs_read    = 1'b0;
    data        = avs_readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0; pio_in = '0;
    idle(3);
    checks++; if (pio_out !== 24'hA5A5A5) $display("[TB] FAIL reset_pio_out got %h want a5a5a5", pio_out); else passed++;
    checks++; if (irq !== 1'b0) $display("[TB] FAIL reset_irq got %b want 0", irq); else passed++;
    checks++; if (avs_readdata !== 32'h0) $display("[TB] FAIL reset_readdata got %h want 0", avs_readdata); else passed++;
    reset_n = 1'b1;
    idle(2);
    bus_read(2'd0, 3'd1, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL reset_in got %h want 0", rd); else passed++;
    bus_read(2'd0, 3'd2, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL reset_mask got %h want 0", rd); else passed++;
    bus_read(2'd1, 3'd3, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL reset_edge got %h want 0", rd); else passed++;
  endtask

  task automatic test_data_set_clr();
    logic [31:0] rd;
    bus_write(2'd0, 3'd0, 32'h0000_00FF, 4'b0000);
    checks++; if (pio_out[7:0] !== 8'hA5) $display("[TB] FAIL data_be0 got %h want a5", pio_out[7:0]); else passed++;
    bus_write(2'd0, 3'd0, 32'h0000_003C, 4'b0001);
    checks++; if (pio_out[7:0] !== 8'h3C) $display("[TB] FAIL data_be1 got %h want 3c", pio_out[7:0]); else passed++;
    bus_write(2'd1, 3'd4, 32'h0000_000F, 4'b1111);
    checks++; if (pio_out[15:8] !== 8'hAF) $display("[TB] FAIL set_ch1 got %h want af", pio_out[15:8]); else passed++;
    bus_write(2'd1, 3'd5, 32'h0000_0003, 4'b1111);
    checks++; if (pio_out !== 24'hA5AC3C) $display("[TB] FAIL clr_ch1 got %h want a5ac3c", pio_out); else passed++;
    idle(1);
    avs_address = {2'd1, 3'd0};
    avs_read    = 1'b1;
    checks++; if (avs_readdata !== 32'h0) $display("[TB] FAIL read_latency_early got %h want 0", avs_readdata); else passed++;
    @(posedge clk); #1;
    avs_read = 1'b0;
    checks++; if (avs_readdata !== 32'h0000_00AC) $display("[TB] FAIL read_latency_data got %h want ac", avs_readdata); else passed++;
    bus_read(2'd1, 3'd4, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL set_reads0 got %h want 0", rd); else passed++;
    bus_read(2'd1, 3'd5, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL clr_reads0 got %h want 0", rd); else passed++;
    bus_read(2'd0, 3'd7, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL reg7_reads0 got %h want 0", rd); else passed++;
`ifndef PIO_PWM_EN
    bus_read(2'd0, 3'd6, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL reg6_reads0 got %h want 0", rd); else passed++;
`endif
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd;
    bus_write(2'd0, 3'd2, 32'h0000_0008, 4'b0001);
    pio_in[3] = 1'b1;
    idle(2);
    bus_read(2'd0, 3'd3, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL edge_not_yet got %h want 0", rd); else passed++;
    checks++; if (irq !== 1'b0) $display("[TB] FAIL irq_not_yet got %b want 0", irq); else passed++;
    bus_read(2'd0, 3'd3, rd);
    checks++; if (rd !== 32'h8) $display("[TB] FAIL edge_cycle3 got %h want 8", rd); else passed++;
    checks++; if (irq !== 1'b1) $display("[TB] FAIL irq_cycle4 got %b want 1", irq); else passed++;
    bus_read(2'd0, 3'd1, rd);
    checks++; if (rd !== 32'h8) $display("[TB] FAIL in_sync got %h want 8", rd); else passed++;
    bus_write(2'd0, 3'd3, 32'h0000_0008, 4'b0001);
    checks++; if (irq !== 1'b1) $display("[TB] FAIL irq_hold_w1c got %b want 1", irq); else passed++;
    idle(1);
    checks++; if (irq !== 1'b0) $display("[TB] FAIL irq_clear got %b want 0", irq); else passed++;
    pio_in[3] = 1'b0;
    idle(5);
    checks++; if (irq !== 1'b0) $display("[TB] FAIL fall_irq got %b want 0", irq); else passed++;
    bus_read(2'd0, 3'd3, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL fall_no_capture got %h want 0", rd); else passed++;
  endtask

  task automatic test_w1c_collision();
    logic [31:0] rd;
    pio_in[3] = 1'b1;
    idle(5);
    pio_in[3] = 1'b0;
    idle(5);
    pio_in[3] = 1'b1;
    idle(2);
    avs_address = {2'd0, 3'd3}; avs_writedata = 32'h8; avs_byteenable = 4'b0001; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0;
    idle(1);
    checks++; if (irq !== 1'b1) $display("[TB] FAIL collide_irq got %b want 1", irq); else passed++;
    bus_read(2'd0, 3'd3, rd);
    checks++; if (rd !== 32'h8) $display("[TB] FAIL collide_edge got %h want 8", rd); else passed++;
    bus_write(2'd0, 3'd3, 32'h0000_0008, 4'b0001);
    idle(1);
    checks++; if (irq !== 1'b0) $display("[TB] FAIL collide_cleanup_irq got %b want 0", irq); else passed++;
    bus_read(2'd0, 3'd3, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL collide_cleanup_edge got %h want 0", rd); else passed++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd;
    bus_write(2'd3, 3'd0, 32'h0000_0055, 4'b1111);
    bus_write(2'd3, 3'd4, 32'h0000_00FF, 4'b1111);
    checks++; if (pio_out !== 24'hA5AC3C) $display("[TB] FAIL oor_write got %h want a5ac3c", pio_out); else passed++;
    bus_read(2'd3, 3'd0, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL oor_read_data got %h want 0", rd); else passed++;
    bus_read(2'd3, 3'd1, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL oor_read_in got %h want 0", rd); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_write(2'd0, 3'd3, 32'h0000_0008, 4'b0000);
    avs_address = {2'd1, 3'd0};
    avs_read    = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    checks++; if (avs_readdata !== 32'hAC) $display("[TB] FAIL mid_read got %h want ac", avs_readdata); else passed++;
    reset_n = 1'b0;
    #1;
    checks++; if (avs_readdata !== 32'h0) $display("[TB] FAIL mid_reset_rd got %h want 0", avs_readdata); else passed++;
    checks++; if (pio_out !== 24'hA5A5A5) $display("[TB] FAIL mid_reset_out got %h want a5a5a5", pio_out); else passed++;
    pio_in = '0;
    idle(2);
    reset_n = 1'b1;
    idle(5);
    checks++; if (irq !== 1'b0) $display("[TB] FAIL post_reset_irq got %b want 0", irq); else passed++;
    bus_read(2'd0, 3'd3, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL post_reset_edge got %h want 0", rd); else passed++;
    bus_read(2'd0, 3'd2, rd);
    checks++; if (rd !== 32'h0) $display("[TB] FAIL post_reset_mask got %h want 0", rd); else passed++;
  endtask

`ifdef PIO_PWM_EN
  task automatic test_pwm();
    logic [31:0] rd;
    logic        prev;
    logic        found;
    int          hi;
    bus_read(2'd0, 3'd6, rd);
    checks++; if (rd !== 32'hFF) $display("[TB] FAIL duty_reset got %h want ff", rd); else passed++;
    bus_write(2'd0, 3'd6, 32'd64, 4'b0001);
    prev  = pio_out[0];
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(posedge clk); #1;
      if (!prev && pio_out[0]) found = 1'b1;
      prev = pio_out[0];
    end
    checks++; if (found !== 1'b1) $display("[TB] FAIL pwm_wrap_timeout got %b want 1", found); else passed++;
    hi = 1;
    for (int i = 1; i < 256; i++) begin
      if (i == 10) begin
        avs_address = {2'd0, 3'd6}; avs_writedata = 32'd192; avs_byteenable = 4'b0001; avs_write = 1'b1;
      end
      if (i == 11) avs_write = 1'b0;
      @(posedge clk); #1;
      hi += int'(pio_out[0]);
    end
    checks++; if (hi !== 64) $display("[TB] FAIL pwm_duty64 got %0d want 64", hi); else passed++;
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      hi += int'(pio_out[0]);
    end
    checks++; if (hi !== 192) $display("[TB] FAIL pwm_duty192 got %0d want 192", hi); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_data_set_clr();
    test_edge_irq();
    test_w1c_collision();
    test_out_of_range();
    test_reset_mid();
`ifdef PIO_PWM_EN
    test_pwm();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
